// File: rtl/delay_pkg.sv
// Shared types and helpers for the SDF FFT sample delay line.
// Optional build macro: DELAY_RAM_EN (selects circular-buffer storage).
package delay_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

    // Sample counter width: enough bits to count 0 .. 2*DELAY-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/delay_ctrl.sv
// Control for the delay line: sample index counter (switch_enable) and
// saturating fill counter (out_valid). Only enabled edges advance state.
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic out_valid,
    output logic switch_enable
);

    localparam int AW = $clog2(DELAY);
    localparam int CW = cnt_width(DELAY);

    logic [CW-1:0] cnt_r;
    logic [AW-1:0] fill_r;
    logic          valid_r;

    // Sample index counter; wraps naturally at 2*DELAY since DELAY is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fill counter: valid is set on the edge accepting sample DELAY-1 and stays set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_r  <= {AW{1'b0}};
            valid_r <= 1'b0;
        end else if (enable && !valid_r) begin
            if (fill_r == AW'(DELAY - 1)) begin
                valid_r <= 1'b1;
                fill_r  <= fill_r;
            end else begin
                valid_r <= 1'b0;
                fill_r  <= fill_r + AW'(1);
            end
        end else begin
            valid_r <= valid_r;
            fill_r  <= fill_r;
        end
    end

    assign out_valid     = valid_r;
    assign switch_enable = cnt_r[AW];

endmodule

// File: rtl/delay_line.sv
// Parameterised sample delay line for SDF FFT stages.
// Default storage is a shift register; defining DELAY_RAM_EN selects a
// circular buffer with a registered read port, cycle-identical in behaviour.
module delay_line
    import delay_pkg::*;
#(
    parameter int DELAY      = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic                  switch_enable
);

    localparam int AW = $clog2(DELAY);

    generate
        if ((DELAY < 2) || ((DELAY & (DELAY - 1)) != 0)) begin : g_bad_delay
            $error("delay_line: DELAY must be a power of 2 and >= 2");
        end
    endgenerate

    delay_ctrl #(
        .DELAY(DELAY)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .out_valid    (out_valid),
        .switch_enable(switch_enable)
    );

`ifdef DELAY_RAM_EN

    logic [DATA_WIDTH-1:0] mem_r [DELAY];
    logic [AW-1:0]         ptr_r;
    logic [AW-1:0]         rd_ptr_s;
    logic [DATA_WIDTH-1:0] out_r;

    // The oldest entry sits one past the write pointer; reading it into the
    // output register makes total latency DELAY edges, matching the shift register.
    assign rd_ptr_s = ptr_r + AW'(1);

    // Circular buffer: register the oldest entry, overwrite the slot at the pointer, advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DELAY; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            ptr_r <= {AW{1'b0}};
            out_r <= {DATA_WIDTH{1'b0}};
        end else if (enable) begin
            out_r        <= mem_r[rd_ptr_s];
            mem_r[ptr_r] <= in;
            ptr_r        <= ptr_r + AW'(1);
        end else begin
            out_r <= out_r;
            ptr_r <= ptr_r;
        end
    end

    assign out = out_r;

`else

    logic [DATA_WIDTH-1:0] stage_r [DELAY];

    // Shift register: new sample enters stage 0, every stage moves one step on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DELAY; i++) begin
                stage_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (enable) begin
            stage_r[0] <= in;
            for (int i = 1; i < DELAY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end else begin
            for (int i = 0; i < DELAY; i++) begin
                stage_r[i] <= stage_r[i];
            end
        end
    end

    assign out = stage_r[DELAY-1];

`endif

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: two instances (DELAY=2 and DELAY=8)
// share one input stream and are checked every cycle against a history-based
// reference model (out = sample accepted DELAY enabled edges ago).
module tb_delay_line;
    import delay_pkg::*;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] din;
    logic [15:0] dout2;
    logic [15:0] dout8;
    logic        valid2;
    logic        valid8;
    logic        sw2;
    logic        sw8;

    int total = 0;
    int bad   = 0;

    sample_t hist[$];

    delay_line #(.DELAY(2), .DATA_WIDTH(16)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in           (din),
        .out          (dout2),
        .out_valid    (valid2),
        .switch_enable(sw2)
    );

    delay_line #(.DELAY(8), .DATA_WIDTH(16)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in           (din),
        .out          (dout8),
        .out_valid    (valid8),
        .switch_enable(sw8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare both instances against the model for the current cycle.
    task automatic check_all();
        int n;
        int d;
        logic [15:0] e_out;
        n = hist.size();
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 2 : 8;
            e_out = (n >= d) ? hist[n-d] : 16'h0000;
            if (k == 0) begin
                cmp("out_d2",   dout2,         e_out);
                cmp("valid_d2", {15'd0, valid2}, {15'd0, (n >= d)});
                cmp("sw_d2",    {15'd0, sw2},    {15'd0, ((n % (2*d)) >= d)});
            end else begin
                cmp("out_d8",   dout8,         e_out);
                cmp("valid_d8", {15'd0, valid8}, {15'd0, (n >= d)});
                cmp("sw_d8",    {15'd0, sw8},    {15'd0, ((n % (2*d)) >= d)});
            end
        end
    endtask

    // One cycle: drive at negedge, check, take the edge, update model.
    task automatic cycle(input logic en, input logic [15:0] d);
        enable = en;
        din    = d;
        #1;
        check_all();
        @(posedge clk);
        if (en) hist.push_back(d);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges, checked immediately.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        hist.delete();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        din    = 16'h0000;
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Basic stream 4,5,6,7,0,0
        cycle(1'b1, 16'd4);
        cycle(1'b1, 16'd5);
        cycle(1'b1, 16'd6);
        cycle(1'b1, 16'd7);
        cycle(1'b1, 16'd0);
        cycle(1'b1, 16'd0);

        // Same stream with a two-cycle enable gap after sample 5
        async_reset();
        cycle(1'b1, 16'd4);
        cycle(1'b1, 16'd5);
        cycle(1'b0, 16'hDEAD);
        cycle(1'b0, 16'hBEEF);
        cycle(1'b1, 16'd6);
        cycle(1'b1, 16'd7);
        cycle(1'b1, 16'd0);
        cycle(1'b1, 16'd0);

        // Mid-stream async reset, then refill with 1,2,3
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(100 + i));
        async_reset();
        cycle(1'b1, 16'd1);
        cycle(1'b1, 16'd2);
        cycle(1'b1, 16'd3);
        cycle(1'b1, 16'd0);

        // Ramp 0..31 plus flush: exercises DELAY=8 fill, switch and wrap
        async_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'(i));
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0000);

        // Extreme values alternating
        for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2 == 0) ? 16'hFFFF : 16'h0000);

        // Random enable and data with occasional resets
        async_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end
            cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
